vm_dut_top: RTL and testbench
=============================

VM_DUT_TOP -- requirements
Module: vm_dut_top

Interface
REQ-001 Parameter NUM_PROD, 4, number of products (fixed at 4; 2-bit product id).
REQ-002 Parameter PRICE0/PRICE1/PRICE2/PRICE3, 5/10/15/20, product price in credit units.
REQ-003 Parameter STOCK_INIT, 8, items per product after reset.
REQ-004 Parameter MAX_CREDIT, 99, credit ceiling.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 coin_valid  in  1  coin inserted this cycle.
REQ-008 coin_type  in  2  00=1, 01=2, 10=5, 11=10 units.
REQ-009 sel_valid  in  1  product select request.
REQ-010 sel_id  in  2  requested product.
REQ-011 cancel  in  1  refund request.
REQ-012 credit  out  8  current accumulated credit.
REQ-013 coin_reject  out  1  one-cycle pulse, coin returned unaccepted.
REQ-014 dispense  out  1  one-cycle pulse, product released.
REQ-015 dispense_id  out  2  product released, valid with dispense.
REQ-016 change_valid  out  1  one-cycle pulse, change paid.
REQ-017 change_amt  out  8  change value, valid with change_valid, else 0.
REQ-018 no_funds  out  1  one-cycle pulse, credit < price.
REQ-019 sold_out  out  1  one-cycle pulse, selected product stock 0.
REQ-020 busy  out  1  high in VEND and REFUND states.

Function
REQ-021 FSM states IDLE (credit=0), COLLECT (credit>0), VEND, REFUND; all outputs registered.
REQ-022 Accepted coin at edge N: credit increases by coin value, visible after edge N; IDLE->COLLECT.
REQ-023 Coin making credit exceed MAX_CREDIT is rejected: credit unchanged, coin_reject pulses the next cycle.
REQ-024 Coin during VEND or REFUND, or in same cycle as sel_valid or cancel, is rejected (coin_reject pulse).
REQ-025 Priority when simultaneous: cancel > sel_valid > coin_valid.
REQ-026 sel_valid in IDLE/COLLECT: if stock[sel_id]=0 -> sold_out pulse, credit unchanged; else if credit < price -> no_funds pulse, credit unchanged; else -> VEND.
REQ-027 VEND (one cycle): dispense=1, dispense_id=sel_id, stock[sel_id] decremented, change_amt=credit-price, change_valid=1 only if change_amt>0; credit cleared to 0; next state IDLE.
REQ-028 Exact payment: dispense pulses, change_valid stays 0.
REQ-029 cancel in COLLECT -> REFUND (one cycle): change_valid=1, change_amt=credit, credit cleared, next IDLE.
REQ-030 cancel in IDLE: no response, no pulses.
REQ-031 sel_valid and cancel ignored while busy=1.
REQ-032 Stock counters 4 bits, saturate at 0, never wrap; stock not externally refillable (reset only).
REQ-033 Credit arithmetic 8-bit unsigned; never exceeds MAX_CREDIT; never negative.
REQ-034 Response latency: request at edge N, pulse asserted for exactly cycle N..N+1 (one clock).

Reset
REQ-035 rst_n=0 forces asynchronously: state IDLE, credit=0, all pulses 0, dispense_id=0, change_amt=0, busy=0, all stock=STOCK_INIT.
REQ-036 Reset mid-VEND/REFUND aborts: no dispense, no change, credit lost.
REQ-037 First operation accepted on first rising edge after rst_n deasserts.

Verification
REQ-038 Coins 10,10 then sel_id=3 -> dispense=1, dispense_id=3, no change_valid, credit=0.
REQ-039 Coins 10,5,2 then sel_id=1 -> dispense id 1, change_valid=1, change_amt=7, credit=0.
REQ-040 Coin 5 then sel_id=2 -> no_funds=1, credit stays 5; then cancel -> change_amt=5, credit=0.
REQ-041 Credit 95 then coin 10 -> coin_reject=1, credit stays 95; coin 2 accepted -> 97.
REQ-042 Nine purchases of product 0 (coin 5 each) -> first eight dispense, ninth sold_out=1, credit stays 5.
REQ-043 rst_n low during VEND cycle -> dispense=0, credit=0, stock restored to 8.

Source files
------------

// File: rtl/vm_dut_top.sv
// Vending machine controller: takes coins, sells four products from
// per-product stock, and pays back change or a refund. All outputs are registered.
module vm_dut_top #(
  parameter int NUM_PROD   = 4,
  parameter int PRICE0     = 5,
  parameter int PRICE1     = 10,
  parameter int PRICE2     = 15,
  parameter int PRICE3     = 20,
  parameter int STOCK_INIT = 8,
  parameter int MAX_CREDIT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       coin_reject,
  output logic       dispense,
  output logic [1:0] dispense_id,
  output logic       change_valid,
  output logic [7:0] change_amt,
  output logic       no_funds,
  output logic       sold_out,
  output logic       busy,
  output logic [1:0] state_dbg
);

  // Request handshake: coin_valid, sel_valid and cancel are single-cycle
  // strobes sampled on each rising edge. They are never back-pressured.
  // While busy=1, selects and cancels are dropped and coins are rejected.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_REFUND  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [3:0] stock_q [NUM_PROD];
  logic [3:0] stock_d [NUM_PROD];
  logic       coin_reject_q, coin_reject_d;
  logic       dispense_q, dispense_d;
  logic [1:0] dispense_id_q, dispense_id_d;
  logic       change_valid_q, change_valid_d;
  logic [7:0] change_amt_q, change_amt_d;
  logic       no_funds_q, no_funds_d;
  logic       sold_out_q, sold_out_d;

  logic [7:0] coin_val;
  logic [8:0] coin_sum;
  logic [7:0] sel_price;

  always_comb begin
    coin_val = 8'd1;
    case (coin_type)
      2'b00:   coin_val = 8'd1;
      2'b01:   coin_val = 8'd2;
      2'b10:   coin_val = 8'd5;
      default: coin_val = 8'd10;
    endcase
  end

  always_comb begin
    sel_price = 8'(PRICE0);
    case (sel_id)
      2'd0:    sel_price = 8'(PRICE0);
      2'd1:    sel_price = 8'(PRICE1);
      2'd2:    sel_price = 8'(PRICE2);
      default: sel_price = 8'(PRICE3);
    endcase
  end

  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    coin_reject_d  = 1'b0;
    dispense_d     = 1'b0;
    dispense_id_d  = dispense_id_q;
    change_valid_d = 1'b0;
    change_amt_d   = 8'd0;
    no_funds_d     = 1'b0;
    sold_out_d     = 1'b0;
    case (state_q)
      S_VEND, S_REFUND: begin
        state_d       = S_IDLE;
        coin_reject_d = coin_valid;
      end
      default: begin
        if (cancel) begin
          // A coin arriving alongside a cancel or select is always returned.
          coin_reject_d = coin_valid;
          if (state_q == S_COLLECT) begin
            state_d        = S_REFUND;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
            credit_d       = 8'd0;
          end
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (stock_q[sel_id] == 4'd0) begin
            sold_out_d = 1'b1;
          end else if (credit_q < sel_price) begin
            no_funds_d = 1'b1;
          end else begin
            state_d         = S_VEND;
            dispense_d      = 1'b1;
            dispense_id_d   = sel_id;
            stock_d[sel_id] = stock_q[sel_id] - 4'd1;
            change_amt_d    = credit_q - sel_price;
            change_valid_d  = (credit_q != sel_price);
            credit_d        = 8'd0;
          end
        end else if (coin_valid) begin
          if (coin_sum > 9'(MAX_CREDIT)) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[7:0];
            state_d  = S_COLLECT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      credit_q       <= 8'd0;
      for (int i = 0; i < NUM_PROD; i++) stock_q[i] <= 4'(STOCK_INIT);
      coin_reject_q  <= 1'b0;
      dispense_q     <= 1'b0;
      dispense_id_q  <= 2'd0;
      change_valid_q <= 1'b0;
      change_amt_q   <= 8'd0;
      no_funds_q     <= 1'b0;
      sold_out_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      coin_reject_q  <= coin_reject_d;
      dispense_q     <= dispense_d;
      dispense_id_q  <= dispense_id_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      no_funds_q     <= no_funds_d;
      sold_out_q     <= sold_out_d;
    end
  end

  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign dispense     = dispense_q;
  assign dispense_id  = dispense_id_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign no_funds     = no_funds_q;
  assign sold_out     = sold_out_q;
  assign busy         = (state_q == S_VEND) || (state_q == S_REFUND);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vm_dut_top.sv
// Bench for vm_dut_top: directed vector table, hand-written stock/reset
// sequences, and a randomized run scored against a credit/stock model.
module tb_vm_dut_top;

  logic       clk, rst_n;
  logic       coin_valid, sel_valid, cancel;
  logic [1:0] coin_type, sel_id;
  logic [7:0] credit, change_amt;
  logic       coin_reject, dispense, change_valid, no_funds, sold_out, busy;
  logic [1:0] dispense_id, state_dbg;

  int total = 0;
  int bad   = 0;

  vm_dut_top dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .credit(credit),
    .coin_reject(coin_reject), .dispense(dispense), .dispense_id(dispense_id),
    .change_valid(change_valid), .change_amt(change_amt), .no_funds(no_funds),
    .sold_out(sold_out), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cv;  logic [1:0] ct;  logic sv;  logic [1:0] sid;  logic can;
    logic [7:0] credit; logic disp; logic [1:0] did; logic chv; logic [7:0] cha;
    logic nf; logic so; logic rej; logic busy;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic cv, logic [1:0] ct, logic sv, logic [1:0] sid,
                             logic can, logic [7:0] cr, logic disp, logic [1:0] did,
                             logic chv, logic [7:0] cha, logic nf, logic so,
                             logic rej, logic bz);
    vec_t r;
    r.cv = cv; r.ct = ct; r.sv = sv; r.sid = sid; r.can = can;
    r.credit = cr; r.disp = disp; r.did = did; r.chv = chv; r.cha = cha;
    r.nf = nf; r.so = so; r.rej = rej; r.busy = bz;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(logic cv, logic [1:0] ct, logic sv, logic [1:0] sid, logic can);
    @(negedge clk);
    coin_valid = cv; coin_type = ct; sel_valid = sv; sel_id = sid; cancel = can;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_credit"}, credit, 0);
    chk({tag, "_pulses"}, {coin_reject, dispense, change_valid, no_funds, sold_out}, 0);
    chk({tag, "_did"}, dispense_id, 0);
    chk({tag, "_cha"}, change_amt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    coin_valid = 0; coin_type = 0; sel_valid = 0; sel_id = 0; cancel = 0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Nine attempts to buy product 0 with a single 5-unit coin each.
  task automatic buy9();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 2'b10, 1'b0, 2'd0, 1'b0);
      chk("buy_coin_credit", credit, 5);
      drive(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
      if (k < 8) begin
        chk("buy_dispense", {dispense, dispense_id, change_valid, sold_out}, 5'b10000);
        chk("buy_credit", credit, 0);
        idle();
      end else begin
        chk("buy9_sold_out", {sold_out, dispense, no_funds}, 3'b100);
        chk("buy9_credit", credit, 5);
      end
    end
  endtask

  // reference model + scoreboard
  int   m_credit;
  int   m_stock[4];
  bit   m_busy;
  logic [23:0] exp_q[$];

  function automatic int coin_units(logic [1:0] t);
    int tab[4] = '{1, 2, 5, 10};
    return tab[t];
  endfunction

  function automatic int price_of(logic [1:0] id);
    return 5 * (int'(id) + 1);
  endfunction

  function automatic logic [23:0] pack(logic [7:0] cr, logic disp, logic [1:0] did,
                                       logic chv, logic [7:0] cha, logic nf,
                                       logic so, logic rej, logic bz);
    return {cr, disp, (disp ? did : 2'd0), chv, cha, nf, so, rej, bz};
  endfunction

  task automatic model_reset();
    m_credit = 0;
    m_busy   = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 8;
  endtask

  task automatic model_step(logic cv, logic [1:0] ct, logic sv, logic [1:0] sid, logic can);
    logic disp = 0, chv = 0, nf = 0, so = 0, rej = 0;
    int   cha = 0;
    if (m_busy) begin
      rej = cv;
      m_busy = 0;
    end else if (can) begin
      rej = cv;
      if (m_credit > 0) begin
        chv = 1; cha = m_credit; m_credit = 0; m_busy = 1;
      end
    end else if (sv) begin
      rej = cv;
      if (m_stock[sid] == 0) so = 1;
      else if (m_credit < price_of(sid)) nf = 1;
      else begin
        disp = 1; m_stock[sid]--;
        cha = m_credit - price_of(sid); chv = (cha > 0);
        m_credit = 0; m_busy = 1;
      end
    end else if (cv) begin
      if (m_credit + coin_units(ct) > 99) rej = 1;
      else m_credit += coin_units(ct);
    end
    exp_q.push_back(pack(8'(m_credit), disp, sid, chv, 8'(cha), nf, so, rej, m_busy));
  endtask

  initial begin
    vec_t r;
    logic [23:0] e, a;
    logic cv, sv, can;
    logic [1:0] ct, sid;

    rst_n = 1'b0;
    coin_valid = 0; coin_type = 0; sel_valid = 0; sel_id = 0; cancel = 0;
    do_reset();

    // directed vector table, starting from fresh reset
    tbl.push_back(v(1,3,0,0,0, 10,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,3,0,0,0, 20,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,3,0,  0,1,3,0,0, 0,0,0,1));  // exact payment
    tbl.push_back(v(1,3,1,0,1,  0,0,0,0,0, 0,0,1,0));  // busy: sel/cancel dropped
    tbl.push_back(v(1,3,0,0,0, 10,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,2,0,0,0, 15,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,1,0,0,0, 17,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,1,0,  0,1,1,1,7, 0,0,0,1));  // change 7
    tbl.push_back(v(0,0,0,0,0,  0,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,2,0,0,0,  5,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,2,0,  5,0,0,0,0, 1,0,0,0));  // no funds
    tbl.push_back(v(0,0,0,0,1,  0,0,0,1,5, 0,0,0,1));  // refund
    tbl.push_back(v(0,0,0,0,0,  0,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,  0,0,0,0,0, 0,0,0,0));  // cancel in idle
    tbl.push_back(v(1,3,1,0,0,  0,0,0,0,0, 1,0,1,0));
    tbl.push_back(v(1,3,0,0,1,  0,0,0,0,0, 0,0,1,0));
    for (int i = 1; i <= 9; i++)
      tbl.push_back(v(1,3,0,0,0, 8'(10*i),0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,2,0,0,0, 95,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,3,0,0,0, 95,0,0,0,0, 0,0,1,0));  // over ceiling
    tbl.push_back(v(1,1,0,0,0, 97,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,1,0,0,0, 99,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 99,0,0,0,0, 0,0,1,0));
    tbl.push_back(v(0,0,0,0,1,  0,0,0,1,99, 0,0,0,1));
    tbl.push_back(v(0,0,0,0,0,  0,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,2,0,0,0,  5,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,3,1,0,1,  0,0,0,1,5, 0,0,1,1));  // cancel beats sel and coin
    tbl.push_back(v(0,0,0,0,0,  0,0,0,0,0, 0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      drive(r.cv, r.ct, r.sv, r.sid, r.can);
      chk($sformatf("vec%0d_credit", i), credit, r.credit);
      chk($sformatf("vec%0d_flags", i),
          {dispense, change_valid, no_funds, sold_out, coin_reject, busy},
          {r.disp, r.chv, r.nf, r.so, r.rej, r.busy});
      chk($sformatf("vec%0d_change", i), change_amt, r.cha);
      if (r.disp) chk($sformatf("vec%0d_did", i), dispense_id, r.did);
    end

    // stock exhaustion on product 0
    do_reset();
    buy9();

    // reset during the vend cycle, then stock must be back to full
    drive(1'b1, 2'b11, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    chk("vend_before_reset", {dispense, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_vend_reset");
    @(negedge clk);
    rst_n = 1'b1;
    coin_valid = 1'b1; coin_type = 2'b10; sel_valid = 0; cancel = 0;
    @(posedge clk);
    #1;
    chk("first_edge_after_reset", credit, 5);
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    chk("refund_after_reset", {change_valid, change_amt}, {1'b1, 8'd5});
    idle();
    buy9();

    // randomized run against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      cv  = ($urandom_range(99) < 45);
      ct  = 2'($urandom_range(3));
      sv  = ($urandom_range(99) < 15);
      sid = 2'($urandom_range(3));
      can = ($urandom_range(99) < 4);
      model_step(cv, ct, sv, sid, can);
      drive(cv, ct, sv, sid, can);
      e = exp_q.pop_front();
      a = pack(credit, dispense, dispense_id, change_valid, change_amt,
               no_funds, sold_out, coin_reject, busy);
      chk($sformatf("rand%0d", n), a, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
